bus_bridge: RTL and testbench
=============================

BUS_BRIDGE -- requirements
Module: bus_bridge

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, cycles per seven-segment digit slot.
REQ-002 SHALL have parameter TICK_DIV, default 25000, cycles per timer increment.
REQ-003 cpu_clk  in  1  sole clock; all state updates on rising edge.
REQ-004 cpu_rst  in  1  reset, asynchronous, active-low.
REQ-005 Bus_addr  in  32  CPU byte address.
REQ-006 Bus_wen  in  1  CPU write enable.
REQ-007 Bus_wdata  in  32  CPU write data.
REQ-008 Bus_rdata  out  32  read data to CPU.
REQ-009 dram_addr  out  16  DRAM word address, equal to Bus_addr[17:2].
REQ-010 dram_rdata  in  32  DRAM read data.
REQ-011 dram_we  out  1  DRAM write enable.
REQ-012 dram_wdata  out  32  DRAM write data, equal to Bus_wdata.
REQ-013 sw  in  24  asynchronous switch inputs.
REQ-014 btn  in  5  asynchronous button inputs.
REQ-015 led  out  24  LED drive, active-high.
REQ-016 dig_en  out  8  digit enables, active-low one-hot.
REQ-017 dig_seg  out  8  segments {DP,G,F,E,D,C,B,A}, active-low.

Function
REQ-018 SHALL treat Bus_addr[31:12]==20'hFFFFF as peripheral space; all other addresses are DRAM.
REQ-019 SHALL drive dram_we = Bus_wen AND NOT peripheral; dram_we SHALL be 0 for peripheral accesses.
REQ-020 SHALL return Bus_rdata combinationally, same cycle as Bus_addr: DRAM space gives dram_rdata; peripheral space gives the register map below.
REQ-021 The register map SHALL be: 0xFFFFF000 DIG, 32-bit, R/W; 0xFFFFF020 TIMER, 32-bit, R/W; 0xFFFFF060 LED, R/W, low 24 bits; 0xFFFFF070 SW, RO, {8'b0,sw_sync}; 0xFFFFF078 BTN, RO, {27'b0,btn_sync}.
REQ-022 Reads of unmapped peripheral addresses SHALL return 0; writes to them and to RO registers SHALL be ignored.
REQ-023 Peripheral writes SHALL take effect at the rising edge on which Bus_wen=1, visible on reads the next cycle.
REQ-024 LED write SHALL load Bus_wdata[23:0]; led SHALL equal the LED register.
REQ-025 sw and btn SHALL pass through two-flop synchronizers; SW/BTN reads SHALL reflect input changes exactly 2 cycles later.
REQ-026 Prescaler SHALL count 0..TICK_DIV-1 and wrap; TIMER SHALL increment by 1 on the cycle the prescaler wraps; 0xFFFFFFFF+1 SHALL wrap to 0.
REQ-027 TIMER write SHALL load Bus_wdata and clear the prescaler; a write SHALL win over a simultaneous tick.
REQ-028 Scan counter SHALL count 0..SCAN_DIV-1; on wrap, digit index SHALL advance 0..7 and wrap 7->0.
REQ-029 For index i, dig_en SHALL have only bit i low, and dig_seg SHALL encode DIG[4i+3:4i].
REQ-030 Hex codes SHALL be: 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E (DP always 1).
REQ-031 dig_en and dig_seg SHALL be registered, updating one cycle after an index or DIG change.
REQ-032 DIG writes SHALL NOT reset the scan counter or digit index.

Reset
REQ-033 cpu_rst low SHALL immediately clear DIG, TIMER, prescaler, LED, the synchronizers, the scan counter and the digit index, regardless of any operation in progress.
REQ-034 During and after reset, outputs SHALL be: led=0, dig_en=8'hFE, dig_seg=8'hC0; dram_we SHALL follow REQ-019 even while in reset.

Verification
REQ-035 Write 0x12345678 to 0x00000100 -> dram_we=1, dram_addr=0x0040, dram_wdata=0x12345678; read 0x00000100 with dram_rdata=0xCAFEF00D -> Bus_rdata=0xCAFEF00D.
REQ-036 Write 0xFFABCDEF to 0xFFFFF060 -> dram_we=0, led=0xABCDEF next cycle; read 0xFFFFF060 -> 0x00ABCDEF; read 0xFFFFF040 -> 0.
REQ-037 Set sw=0x00A5A5 -> SW read gives 0x00A5A5 after 2 cycles and the old value before that.
REQ-038 TICK_DIV=4: after reset TIMER=1 at cycle 4; write 0xFFFFFFFF on a tick cycle -> TIMER=0xFFFFFFFF, then 0 four cycles later.
REQ-039 SCAN_DIV=2, DIG=0x0000000A: dig_en steps FE,FD,...,7F,FE every 2 cycles; dig_seg=0x88 while dig_en=FE, 0xC0 otherwise.
REQ-040 Assert cpu_rst mid-scan with TIMER nonzero -> outputs take REQ-034 values without waiting for a clock edge; TIMER reads 0.

Source files
------------

// File: rtl/bus_bridge.sv
// bus_bridge: connects a single-cycle CPU data bus to a DRAM port and a small
// block of memory-mapped peripherals (seven-segment display, free-running
// timer, LEDs, switches and buttons).
//
// Bus protocol: there is no valid/ready handshake. Every cycle is a
// transfer. Bus_rdata is combinational from Bus_addr in the same cycle, and a
// write commits on the rising edge where Bus_wen=1. The CPU never stalls.
//
// Ports
//   cpu_clk     sole clock, rising edge
//   cpu_rst     asynchronous active-low reset
//   Bus_addr    CPU byte address
//   Bus_wen     CPU write enable
//   Bus_wdata   CPU write data
//   Bus_rdata   read data back to the CPU (combinational)
//   dram_addr   DRAM word address (Bus_addr[17:2])
//   dram_rdata  DRAM read data
//   dram_we     DRAM write enable (suppressed for peripheral space)
//   dram_wdata  DRAM write data (Bus_wdata)
//   sw, btn     asynchronous switch/button inputs
//   led         LED drive, active-high
//   dig_en      digit enables, active-low one-hot
//   dig_seg     segments {DP,G,F,E,D,C,B,A}, active-low
//
// Peripheral map (Bus_addr[31:12] == 20'hFFFFF, offset = Bus_addr[11:0]):
//   0x000 DIG   R/W  eight hex digits, digit i in bits [4i+3:4i]
//   0x020 TIMER R/W  increments once every TICK_DIV cycles
//   0x060 LED   R/W  low 24 bits
//   0x070 SW    RO   {8'b0, synchronized sw}
//   0x078 BTN   RO   {27'b0, synchronized btn}
//   anything else reads 0 and ignores writes.
module bus_bridge #(
    parameter int SCAN_DIV = 50000,
    parameter int TICK_DIV = 25000
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic [31:0] Bus_addr,
    input  logic        Bus_wen,
    input  logic [31:0] Bus_wdata,
    output logic [31:0] Bus_rdata,
    output logic [15:0] dram_addr,
    input  logic [31:0] dram_rdata,
    output logic        dram_we,
    output logic [31:0] dram_wdata,
    input  logic [23:0] sw,
    input  logic [4:0]  btn,
    output logic [23:0] led,
    output logic [7:0]  dig_en,
    output logic [7:0]  dig_seg
);

    // Counter widths. A divider of 1 still needs a 1-bit counter.
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    localparam logic [11:0] OFF_DIG   = 12'h000;
    localparam logic [11:0] OFF_TIMER = 12'h020;
    localparam logic [11:0] OFF_LED   = 12'h060;
    localparam logic [11:0] OFF_SW    = 12'h070;
    localparam logic [11:0] OFF_BTN   = 12'h078;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic        periph;
    logic [11:0] offset;
    logic        wr_dig;
    logic        wr_timer;
    logic        wr_led;

    assign periph   = (Bus_addr[31:12] == 20'hFFFFF);
    assign offset   = Bus_addr[11:0];
    assign wr_dig   = Bus_wen && periph && (offset == OFF_DIG);
    assign wr_timer = Bus_wen && periph && (offset == OFF_TIMER);
    assign wr_led   = Bus_wen && periph && (offset == OFF_LED);

    // DRAM side is pure wiring; dram_we depends only on the current bus
    // inputs, so it behaves the same in and out of reset.
    assign dram_addr  = Bus_addr[17:2];
    assign dram_wdata = Bus_wdata;
    assign dram_we    = Bus_wen && !periph;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [31:0]       dig_reg;
    logic [31:0]       timer_reg;
    logic [TICK_W-1:0] presc;
    logic [23:0]       led_reg;
    logic [23:0]       sw_meta;
    logic [23:0]       sw_sync;
    logic [4:0]        btn_meta;
    logic [4:0]        btn_sync;
    logic [SCAN_W-1:0] scan_cnt;
    logic [2:0]        dig_idx;
    logic              tick;

    assign tick = (presc == TICK_LAST);
    assign led  = led_reg;

    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            dig_reg <= '0;
            led_reg <= '0;
        end else begin
            if (wr_dig) dig_reg <= Bus_wdata;
            if (wr_led) led_reg <= Bus_wdata[23:0];
        end
    end

    // Two-flop synchronizers for the asynchronous switch/button inputs.
    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            sw_meta  <= '0;
            sw_sync  <= '0;
            btn_meta <= '0;
            btn_sync <= '0;
        end else begin
            sw_meta  <= sw;
            sw_sync  <= sw_meta;
            btn_meta <= btn;
            btn_sync <= btn_meta;
        end
    end

    // Timer: a CPU write takes priority over a coincident tick and restarts
    // the prescaler so the next increment is a full TICK_DIV cycles away.
    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            presc     <= '0;
            timer_reg <= '0;
        end else if (wr_timer) begin
            presc     <= '0;
            timer_reg <= Bus_wdata;
        end else if (tick) begin
            presc     <= '0;
            timer_reg <= timer_reg + 32'd1;
        end else begin
            presc     <= presc + 1'b1;
        end
    end

    // Display scan: digit index advances once per SCAN_DIV cycles and wraps
    // 7->0 through natural 3-bit overflow. DIG writes do not touch it.
    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            scan_cnt <= '0;
            dig_idx  <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            dig_idx  <= dig_idx + 3'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Active-low hex font, DP bit (bit 7) always off.
    function automatic logic [7:0] hex7seg(input logic [3:0] v);
        logic [7:0] seg;
        case (v)
            4'h0:    seg = 8'hC0;
            4'h1:    seg = 8'hF9;
            4'h2:    seg = 8'hA4;
            4'h3:    seg = 8'hB0;
            4'h4:    seg = 8'h99;
            4'h5:    seg = 8'h92;
            4'h6:    seg = 8'h82;
            4'h7:    seg = 8'hF8;
            4'h8:    seg = 8'h80;
            4'h9:    seg = 8'h90;
            4'hA:    seg = 8'h88;
            4'hB:    seg = 8'h83;
            4'hC:    seg = 8'hC6;
            4'hD:    seg = 8'hA1;
            4'hE:    seg = 8'h86;
            default: seg = 8'h8E;
        endcase
        return seg;
    endfunction

    // Display outputs are registered so they lag the index/DIG by one cycle.
    // Reset values match what index 0 with DIG=0 would produce.
    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            dig_en  <= 8'hFE;
            dig_seg <= 8'hC0;
        end else begin
            dig_en  <= ~(8'd1 << dig_idx);
            dig_seg <= hex7seg(dig_reg[{dig_idx, 2'b00} +: 4]);
        end
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        Bus_rdata = '0;
        if (!periph) begin
            Bus_rdata = dram_rdata;
        end else begin
            case (offset)
                OFF_DIG:   Bus_rdata = dig_reg;
                OFF_TIMER: Bus_rdata = timer_reg;
                OFF_LED:   Bus_rdata = {8'h00, led_reg};
                OFF_SW:    Bus_rdata = {8'h00, sw_sync};
                OFF_BTN:   Bus_rdata = {27'd0, btn_sync};
                default:   Bus_rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_bridge.sv
// Testbench for bus_bridge with small dividers (TICK_DIV=4, SCAN_DIV=2).
// Bus reads push their expected value onto a scoreboard queue and the
// observed Bus_rdata pops and compares against it.
module tb_bus_bridge;

    localparam int TICK_DIV = 4;
    localparam int SCAN_DIV = 2;

    localparam logic [31:0] A_DIG   = 32'hFFFFF000;
    localparam logic [31:0] A_TIMER = 32'hFFFFF020;
    localparam logic [31:0] A_HOLE  = 32'hFFFFF040;
    localparam logic [31:0] A_LED   = 32'hFFFFF060;
    localparam logic [31:0] A_SW    = 32'hFFFFF070;
    localparam logic [31:0] A_BTN   = 32'hFFFFF078;

    // Clock / reset
    logic        cpu_clk = 1'b0;
    logic        cpu_rst = 1'b1;
    always #5 cpu_clk = ~cpu_clk;

    logic [31:0] Bus_addr   = '0;
    logic        Bus_wen    = 1'b0;
    logic [31:0] Bus_wdata  = '0;
    logic [31:0] Bus_rdata;
    logic [15:0] dram_addr;
    logic [31:0] dram_rdata = '0;
    logic        dram_we;
    logic [31:0] dram_wdata;
    logic [23:0] sw         = '0;
    logic [4:0]  btn        = '0;
    logic [23:0] led;
    logic [7:0]  dig_en;
    logic [7:0]  dig_seg;

    bus_bridge #(
        .SCAN_DIV(SCAN_DIV),
        .TICK_DIV(TICK_DIV)
    ) dut (
        .cpu_clk   (cpu_clk),
        .cpu_rst   (cpu_rst),
        .Bus_addr  (Bus_addr),
        .Bus_wen   (Bus_wen),
        .Bus_wdata (Bus_wdata),
        .Bus_rdata (Bus_rdata),
        .dram_addr (dram_addr),
        .dram_rdata(dram_rdata),
        .dram_we   (dram_we),
        .dram_wdata(dram_wdata),
        .sw        (sw),
        .btn       (btn),
        .led       (led),
        .dig_en    (dig_en),
        .dig_seg   (dig_seg)
    );

    // Scoreboard
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] actual,
                            input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, actual, expected);
    endtask

    task automatic sb_push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic sb_pop(input string tag, input logic [31:0] actual);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL %s: scoreboard empty, got 0x%08h", tag, actual);
        end else begin
            e = exp_q.pop_front();
            check_eq(tag, actual, e);
        end
    endtask

    // Driver tasks. step() leaves us 2 time units after a rising edge.
    task automatic step();
        @(posedge cpu_clk);
        #2;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        Bus_addr  = addr;
        Bus_wdata = data;
        Bus_wen   = 1'b1;
        step();
        Bus_wen   = 1'b0;
    endtask

    task automatic bus_read(input string tag, input logic [31:0] addr,
                            input logic [31:0] expected);
        Bus_addr = addr;
        Bus_wen  = 1'b0;
        sb_push(expected);
        #1;
        sb_pop(tag, Bus_rdata);
    endtask

    task automatic check_outputs_reset(input string tag);
        check_eq({tag, "_led"},     {8'h00, led},     32'h0);
        check_eq({tag, "_dig_en"},  {24'h0, dig_en},  32'hFE);
        check_eq({tag, "_dig_seg"}, {24'h0, dig_seg}, 32'hC0);
    endtask

    initial begin
        logic [7:0] prev_en;
        logic [4:0] btn_val;
        bit         found;
        int         d;

        // ---------------- reset ----------------
        #1 cpu_rst = 1'b0;
        #2;
        check_outputs_reset("rst");
        Bus_addr = 32'h0000_0100; Bus_wen = 1'b1;
        #1 check_eq("rst_dram_we_dram", {31'd0, dram_we}, 32'd1);
        Bus_addr = A_LED;
        #1 check_eq("rst_dram_we_periph", {31'd0, dram_we}, 32'd0);
        Bus_wen = 1'b0;
        step();
        check_outputs_reset("rst_hold");
        cpu_rst = 1'b1;

        // ---------------- timer ----------------
        repeat (3) step();
        bus_read("timer_c3", A_TIMER, 32'd0);
        step();
        bus_read("timer_c4", A_TIMER, 32'd1);
        repeat (3) step();
        bus_write(A_TIMER, 32'hFFFF_FFFF);   // lands on the tick edge
        bus_read("timer_write_wins", A_TIMER, 32'hFFFF_FFFF);
        repeat (3) step();
        bus_read("timer_before_wrap", A_TIMER, 32'hFFFF_FFFF);
        step();
        bus_read("timer_wrap", A_TIMER, 32'd0);

        // ---------------- DRAM ----------------
        Bus_addr = 32'h0000_0100; Bus_wdata = 32'h1234_5678; Bus_wen = 1'b1;
        #1;
        check_eq("dram_we",    {31'd0, dram_we},   32'd1);
        check_eq("dram_addr",  {16'h0, dram_addr}, 32'h0040);
        check_eq("dram_wdata", dram_wdata,         32'h1234_5678);
        step();
        Bus_wen = 1'b0;
        dram_rdata = 32'hCAFE_F00D;
        bus_read("dram_rdata", 32'h0000_0100, 32'hCAFE_F00D);
        dram_rdata = $urandom();
        bus_read("dram_rdata_rand", 32'h0003_FFFC, dram_rdata);

        // ---------------- LED / unmapped ----------------
        Bus_addr = A_LED; Bus_wdata = 32'hFFAB_CDEF; Bus_wen = 1'b1;
        #1 check_eq("led_dram_we", {31'd0, dram_we}, 32'd0);
        step();
        Bus_wen = 1'b0;
        check_eq("led_out", {8'h00, led}, 32'h00AB_CDEF);
        bus_read("led_read", A_LED, 32'h00AB_CDEF);
        bus_read("hole_read", A_HOLE, 32'd0);
        bus_write(A_HOLE, 32'h1234_5678);
        bus_read("hole_after_write", A_HOLE, 32'd0);

        // ---------------- switches / buttons ----------------
        sw = 24'h00A5A5;
        bus_read("sw_c0", A_SW, 32'd0);
        step();
        bus_read("sw_c1", A_SW, 32'd0);
        step();
        bus_read("sw_c2", A_SW, 32'h0000_A5A5);
        bus_write(A_SW, 32'hFFFF_FFFF);
        bus_read("sw_ro", A_SW, 32'h0000_A5A5);

        btn_val = 5'($urandom_range(31, 1));
        btn = btn_val;
        step();
        bus_read("btn_c1", A_BTN, 32'd0);
        step();
        bus_read("btn_c2", A_BTN, {27'd0, btn_val});

        // ---------------- display scan ----------------
        bus_write(A_DIG, 32'h0000_000A);
        bus_read("dig_read", A_DIG, 32'h0000_000A);
        repeat (2) step();
        found = 1'b0;
        prev_en = dig_en;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (prev_en == 8'h7F && dig_en == 8'hFE) found = 1'b1;
            else prev_en = dig_en;
        end
        if (!found) check_eq("scan_sync_timeout", 32'd0, 32'd1);
        else begin
            for (int j = 0; j < 18; j++) begin
                d = (j / 2) % 8;
                sb_push({24'h0, ~(8'd1 << d)});
                sb_push((d == 0) ? 32'h88 : 32'hC0);
                sb_pop($sformatf("scan_en_%0d", j),  {24'h0, dig_en});
                sb_pop($sformatf("scan_seg_%0d", j), {24'h0, dig_seg});
                step();
            end
        end

        // ---------------- mid-scan reset ----------------
        bus_write(A_TIMER, 32'd5);
        bus_read("led_pre_reset", A_LED, 32'h00AB_CDEF);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (dig_en == 8'hFD) found = 1'b1;
            else step();
        end
        if (!found) check_eq("midscan_sync_timeout", 32'd0, 32'd1);
        #1 cpu_rst = 1'b0;
        #1;
        check_outputs_reset("midrst");
        bus_read("midrst_timer", A_TIMER, 32'd0);
        bus_read("midrst_dig",   A_DIG,   32'd0);
        Bus_addr = 32'h0000_0200; Bus_wen = 1'b1;
        #1 check_eq("midrst_dram_we", {31'd0, dram_we}, 32'd1);
        Bus_wen = 1'b0;
        repeat (3) step();
        check_outputs_reset("midrst_hold");
        cpu_rst = 1'b1;
        step();

        if (exp_q.size() != 0) check_eq("scoreboard_leftover", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1);
    end

endmodule
